// File: rtl/xbar_cfg_pkg.sv
// rtl/xbar_cfg_pkg.sv - shared crossbar geometry, loader widths and loader state encoding
package xbar_cfg_pkg;

    localparam int XBAR_OUTPUTS = 60;
    localparam int XBAR_SEL_W   = 6;
    localparam int XBAR_INPUTS  = 1 << XBAR_SEL_W;

    localparam int CFG_W  = XBAR_OUTPUTS * XBAR_SEL_W;
    localparam int WORD_W = 32;
    localparam int NWORDS = (CFG_W + WORD_W - 1) / WORD_W;
    localparam int CNT_W  = $clog2(NWORDS);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        LOAD   = 2'd1,
        COMMIT = 2'd2
    } state_t;

endpackage

// File: rtl/xbar_cfg_loader.sv
// rtl/xbar_cfg_loader.sv - staged, atomically committed crossbar config loader (parity check: XBAR_CFG_PARITY_EN)
module xbar_cfg_loader
    import xbar_cfg_pkg::*;
(
    input  logic              clk,
    input  logic              reset,
    input  logic              io_cfg_start,
    input  logic              io_cfg_in_valid,
    output logic              io_cfg_in_ready,
    input  logic [WORD_W-1:0] io_cfg_in_bits,
    input  logic              io_cfg_in_parity,
    output logic              io_busy,
    output logic              io_cfg_done,
    output logic              io_cfg_err,
    output logic [CFG_W-1:0]  io_mux_configs
);

    state_t             state_q, state_d;
    logic [CNT_W-1:0]   count_q, count_d;
    logic [CFG_W-1:0]   staging_q, staging_d;
    logic [CFG_W-1:0]   active_q;
    logic               err_q, err_d;
    logic               accept;
    logic               last_word;
    logic               commit_ok;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // start has priority over a word presented in the same cycle
    always_comb begin
        state_d         = state_q;
        count_d         = count_q;
        io_cfg_in_ready = 1'b0;
        accept          = 1'b0;
        last_word       = 1'b0;
        case (state_q)
            IDLE: begin
                if (io_cfg_start) begin
                    state_d = LOAD;
                    count_d = '0;
                end
            end
            LOAD: begin
                io_cfg_in_ready = !io_cfg_start;
                accept          = io_cfg_in_valid && !io_cfg_start;
                if (io_cfg_start) begin
                    count_d = '0;
                end else if (accept) begin
                    if (count_q == CNT_W'(NWORDS - 1)) begin
                        last_word = 1'b1;
                        state_d   = COMMIT;
                        count_d   = '0;
                    end else begin
                        count_d = count_q + 1'b1;
                    end
                end
            end
            COMMIT: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // bits of the final word beyond CFG_W have no home and simply fall away
    always_comb begin
        staging_d = staging_q;
        for (int i = 0; i < CFG_W; i++) begin
            if (CNT_W'(i / WORD_W) == count_q) begin
                staging_d[i] = io_cfg_in_bits[i % WORD_W];
            end
        end
    end

`ifdef XBAR_CFG_PARITY_EN
    logic word_err;
    assign word_err = accept && (^{io_cfg_in_bits, io_cfg_in_parity});

    always_comb begin
        err_d = err_q;
        if (io_cfg_start && (state_q != COMMIT)) begin
            err_d = 1'b0;
        end
        if (word_err) begin
            err_d = 1'b1;
        end
    end
`else
    logic unused_parity;
    assign unused_parity = io_cfg_in_parity;
    assign err_d         = 1'b0;
`endif

    // active is loaded on the edge into COMMIT so the new image coincides with done
    assign commit_ok = last_word && !err_d;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            count_q   <= '0;
            staging_q <= '0;
            active_q  <= '0;
            err_q     <= 1'b0;
        end else begin
            count_q <= count_d;
            err_q   <= err_d;
            if (accept) begin
                staging_q <= staging_d;
            end
            if (commit_ok) begin
                active_q <= staging_d;
            end
        end
    end

    assign io_busy        = (state_q != IDLE);
    assign io_cfg_done    = (state_q == COMMIT);
    assign io_cfg_err     = err_q;
    assign io_mux_configs = active_q;

endmodule

// File: tb/tb_xbar_cfg_loader.sv
// tb/tb_xbar_cfg_loader.sv - randomized self-checking bench for xbar_cfg_loader
module tb_xbar_cfg_loader;
    import xbar_cfg_pkg::*;

    logic              clk = 1'b0;
    logic              rst_n;
    logic              io_cfg_start;
    logic              io_cfg_in_valid;
    logic              io_cfg_in_ready;
    logic [WORD_W-1:0] io_cfg_in_bits;
    logic              io_cfg_in_parity;
    logic              io_busy;
    logic              io_cfg_done;
    logic              io_cfg_err;
    logic [CFG_W-1:0]  io_mux_configs;

    always #5 clk = ~clk;

    xbar_cfg_loader dut (
        .clk              (clk),
        .reset            (rst_n),
        .io_cfg_start     (io_cfg_start),
        .io_cfg_in_valid  (io_cfg_in_valid),
        .io_cfg_in_ready  (io_cfg_in_ready),
        .io_cfg_in_bits   (io_cfg_in_bits),
        .io_cfg_in_parity (io_cfg_in_parity),
        .io_busy          (io_busy),
        .io_cfg_done      (io_cfg_done),
        .io_cfg_err       (io_cfg_err),
        .io_mux_configs   (io_mux_configs)
    );

    int n_vec = 0;
    int n_bad = 0;
    int done_seen = 0;

    // reference: phase 0 idle, 1 loading, 2 committing; words accepted so far in m_q
    int               m_phase;
    logic [31:0]      m_q[$];
    logic [CFG_W-1:0] m_active;
    logic             m_err;

    function automatic logic [CFG_W-1:0] model_image();
        logic [NWORDS*WORD_W-1:0] p;
        p = '0;
        foreach (m_q[i]) p[i*WORD_W +: WORD_W] = m_q[i];
        return p[CFG_W-1:0];
    endfunction

    task automatic check1(input string tag, input logic obs, input logic exp);
        n_vec++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s: got %b expected %b", tag, obs, exp);
        end
    endtask

    task automatic checkw(input string tag, input logic [CFG_W-1:0] obs, input logic [CFG_W-1:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        m_phase  = 0;
        m_q.delete();
        m_active = '0;
        m_err    = 1'b0;
    endtask

    task automatic check_outputs();
        check1("done", io_cfg_done, m_phase == 2);
        check1("busy", io_busy, m_phase != 0);
        check1("err", io_cfg_err, m_err);
        checkw("mux", io_mux_configs, m_active);
    endtask

    task automatic cyc(input logic st, input logic v, input logic [31:0] w, input logic p);
        io_cfg_start     = st;
        io_cfg_in_valid  = v;
        io_cfg_in_bits   = w;
        io_cfg_in_parity = p;
        #1;
        check1("ready", io_cfg_in_ready, (m_phase == 1) && !st);
        @(posedge clk);
        case (m_phase)
            0: if (st) begin
                m_phase = 1;
                m_q.delete();
                m_err = 1'b0;
            end
            1: if (st) begin
                m_q.delete();
                m_err = 1'b0;
            end else if (v) begin
                m_q.push_back(w);
`ifdef XBAR_CFG_PARITY_EN
                if (^{w, p}) m_err = 1'b1;
`endif
                if (m_q.size() == NWORDS) begin
                    m_phase = 2;
                    if (!m_err) m_active = model_image();
                end
            end
            default: m_phase = 0;
        endcase
        #1;
        if (io_cfg_done) done_seen++;
        check_outputs();
    endtask

    task automatic idle_gap(input int gap_max);
        repeat ($urandom_range(0, gap_max)) cyc(1'b0, 1'b0, $urandom, 1'($urandom));
    endtask

    task automatic send_word(input logic [31:0] w, input logic bad);
        cyc(1'b0, 1'b1, w, (^w) ^ bad);
    endtask

    // leaves the DUT in the COMMIT cycle
    task automatic load_image(input logic [31:0] words[NWORDS], input int gap_max);
        cyc(1'b1, 1'b0, 32'h0, 1'b0);
        for (int i = 0; i < NWORDS; i++) begin
            idle_gap(gap_max);
            send_word(words[i], 1'b0);
        end
    endtask

    logic [31:0] img[NWORDS];
    logic [7:0]  b;

    initial begin
        rst_n            = 1'b0;
        io_cfg_start     = 1'b0;
        io_cfg_in_valid  = 1'b0;
        io_cfg_in_bits   = '0;
        io_cfg_in_parity = 1'b0;
        model_reset();

        // reset held for three cycles, then released
        repeat (3) begin
            @(posedge clk);
            #1;
            check1("rst_ready", io_cfg_in_ready, 1'b0);
            check_outputs();
        end
        rst_n = 1'b1;
        cyc(1'b0, 1'b0, 32'h0, 1'b0);

        // full load of the counting pattern, back to back
        for (int i = 0; i < NWORDS; i++) begin
            b = 8'(i);
            img[i] = {4{b}};
        end
        load_image(img, 0);
        checkw("img_w0", {328'h0, io_mux_configs[31:0]}, '0);
        checkw("img_w1", {328'h0, io_mux_configs[63:32]}, {328'h0, 32'h0101_0101});
        checkw("img_w11", {352'h0, io_mux_configs[359:352]}, {352'h0, 8'h0B});
        io_cfg_in_valid = 1'b1;
        #1;
        check1("ready_commit", io_cfg_in_ready, 1'b0);
        cyc(1'b0, 1'b0, 32'h0, 1'b0);

        // shadowing: new image with gaps; active must hold until commit
        for (int i = 0; i < NWORDS; i++) img[i] = $urandom;
        load_image(img, 3);
        cyc(1'b0, 1'b0, 32'h0, 1'b0);

        // restart mid-load with a word presented alongside start
        done_seen = 0;
        cyc(1'b1, 1'b0, 32'h0, 1'b0);
        for (int i = 0; i < 7; i++) send_word($urandom, 1'b0);
        cyc(1'b1, 1'b1, 32'hDEAD_BEEF, 1'b0);
        for (int i = 0; i < NWORDS; i++) send_word($urandom, 1'b0);
        cyc(1'b0, 1'b0, 32'h0, 1'b0);
        check1("restart_one_done", done_seen == 1, 1'b1);

        // valid in IDLE is not accepted
        repeat (3) cyc(1'b0, 1'b1, $urandom, 1'b0);
        cyc(1'b1, 1'b1, $urandom, 1'b0);
        for (int i = 0; i < NWORDS; i++) send_word($urandom, 1'b0);
        // start during COMMIT is ignored
        cyc(1'b1, 1'b0, 32'h0, 1'b0);
        cyc(1'b0, 1'b0, 32'h0, 1'b0);

        // bad parity on word 3, then a clean load
        cyc(1'b1, 1'b0, 32'h0, 1'b0);
        for (int i = 0; i < NWORDS; i++) send_word($urandom, i == 3);
        cyc(1'b0, 1'b0, 32'h0, 1'b0);
        for (int i = 0; i < NWORDS; i++) img[i] = $urandom;
        load_image(img, 1);
        cyc(1'b0, 1'b0, 32'h0, 1'b0);

        // reset in the middle of a load
        cyc(1'b1, 1'b0, 32'h0, 1'b0);
        for (int i = 0; i < 4; i++) send_word($urandom, 1'b0);
        rst_n = 1'b0;
        model_reset();
        #1;
        check1("midrst_ready", io_cfg_in_ready, 1'b0);
        check_outputs();
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        cyc(1'b0, 1'b0, 32'h0, 1'b0);

        // random loads with gaps, occasional restarts and parity faults
        for (int n = 0; n < 8; n++) begin
            cyc(1'b1, 1'($urandom), $urandom, 1'($urandom));
            for (int i = 0; i < NWORDS; i++) begin
                idle_gap(2);
                if ($urandom_range(0, 19) == 0) cyc(1'b1, 1'($urandom), $urandom, 1'b0);
                send_word($urandom, $urandom_range(0, 9) == 0);
            end
            while (m_phase == 1) send_word($urandom, 1'b0);
            cyc(1'($urandom), 1'($urandom), $urandom, 1'b0);
            idle_gap(2);
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule

// File: doc/xbar_cfg_loader.md
Name: xbar_cfg_loader

Overview:
- Configuration front-end directly upstream of the tile crossbar.
- Accepts a stream of WORD_W-bit config words over a valid/ready handshake and assembles them in a staging register.
- Atomically commits the staged image to the active register that drives the crossbar's io_mux_configs bus.
- The crossbar never sees a partially loaded configuration.

Parameters:
- CFG_W, 360, total mux-select bits (60 outputs x 6-bit selects).
- WORD_W, 32, config word width.
- NWORDS, ceil(CFG_W/WORD_W) = 12, derived (localparam); words per full image.

Ports:
- clk  input  1  single clock.
- reset  input  1  asynchronous, active-low reset.
- io_cfg_start  input  1  pulse; begins (or restarts) a load.
- io_cfg_in_valid  input  1  word valid.
- io_cfg_in_ready  output  1  block accepts a word.
- io_cfg_in_bits  input  WORD_W  config word; word 0 carries bits [WORD_W-1:0].
- io_cfg_in_parity  input  1  even-parity bit for io_cfg_in_bits (used only with the optional feature).
- io_busy  output  1  state != IDLE.
- io_cfg_done  output  1  one-cycle pulse when a load finishes.
- io_cfg_err  output  1  sticky parity error (optional feature).
- io_mux_configs  output  CFG_W  active configuration to the crossbar.

Behaviour:
- Reset (reset=0, async) clears:
  - staging=0, active=0, so io_mux_configs=0 (every xbar output selects input 0);
  - state=IDLE, word count=0;
  - ready=0, busy=0, done=0, err=0.
- States:
  - IDLE: ready=0. io_cfg_start -> LOAD with count=0.
  - LOAD: ready=1. On each valid&&ready edge, staging[count*WORD_W +: WORD_W] <= word; bits at positions >= CFG_W are discarded (word 11 uses bits [7:0] only); count++. Accepting word NWORDS-1 -> COMMIT. Valid low: hold, no timeout.
  - COMMIT: ready=0; active <= staging; done=1 for this cycle; -> IDLE.
- Timing: done is high the cycle after the last word's handshake; io_mux_configs shows the new image in that same cycle. Minimum load time is NWORDS+1 cycles from the first accepted word.
- io_mux_configs changes only on a COMMIT edge. It is stable during LOAD and IDLE.
- Start during LOAD: count resets to 0, state stays LOAD. A word presented in that cycle is NOT accepted, because start has priority and ready is forced low that cycle. Staging is not cleared; later words overwrite it.
- Start during COMMIT: ignored. Commit completes and the block returns to IDLE.
- Start in IDLE with valid high in the same cycle: the word is not accepted (ready=0 in IDLE).
- Reset asserted mid-load: everything returns to reset values, including active.
- Count is clog2(NWORDS) bits wide and never wraps; COMMIT always follows word NWORDS-1.

Optional Feature:
- Macro: XBAR_CFG_PARITY_EN.
- When defined:
  - Each accepted word is checked: ^{io_cfg_in_bits, io_cfg_in_parity} must be 0.
  - A mismatch sets err (sticky).
  - In COMMIT with err=1, active is NOT updated, but done still pulses.
  - err clears on the next accepted io_cfg_start.
- When undefined: parity input ignored, io_cfg_err tied 0, commit unconditional. Port list is identical in both builds.

Decomposition:
- Shared package xbar_cfg_pkg holds:
  - CFG_W, WORD_W, NWORDS, count width;
  - the state enum (IDLE, LOAD, COMMIT).
- The crossbar's width/select constants should live in the same package.
- No sub-module; a single FSM plus two registers.

Test Plan:
- Reset: hold reset=0 for 3 cycles -> io_mux_configs=0, ready=0, busy=0, done=0; release -> outputs unchanged.
- Full load: start, then 12 back-to-back words 0x0000_0000..0x0B0B_0B0B (word i = {4{i[7:0]}}) -> done at the cycle after word 11; io_mux_configs[31:0]=0, [63:32]=0x01010101, [359:352]=0x0B; ready low in COMMIT.
- Shadowing: with active=image A, start and send 5 words of image B with valid gaps -> io_mux_configs stays A throughout; after the 12th word it equals B.
- Restart: send 7 words, pulse start with valid high -> that word is not accepted; the next 12 words complete a clean load; a single done pulse.
- Backpressure/idle: valid high in IDLE -> ready=0, no state change; start during COMMIT -> ignored, busy=0 on the next cycle.
- Parity (XBAR_CFG_PARITY_EN): corrupt parity on word 3 -> err=1, done pulses, io_mux_configs unchanged; the next start clears err and a clean load commits.
